int_ctrl: RTL and testbench
===========================

// Module: int_ctrl
// PURPOSE
//  Bus-mapped interrupt controller directly upstream of the CPU's INTin/INTnum inputs.
//  Edge-detects up to NSRC external request lines and latches them as pending.
//  Masks and prioritises them, then presents one request plus a cause code to the CPU.
//  The handler reads and acknowledges through word loads/stores on the shared BUS.
// PARAMETERS
//  NSRC       8              number of request sources, 1..32
//  BASE_ADDR  32'hFFFF_FF00  byte address of register 0; low 4 bits must be 0
//  CODE_BASE  16             INTnum = CODE_BASE + winning source index
//                            (keeps clear of syscall cause 8)
// PORTS
//  clk       in     1     CPU clock; all state on posedge
//  rst       in     1     synchronous, active-high reset
//  irq_src   in     NSRC  asynchronous request lines; rising edge = request
//  Addr      in     32    CPU memory address
//  Memread   in     1     CPU read strobe
//  Memwrite  in     2     0:none 1:WORD 2:DMA 3:BYTE
//  BUS       inout  32    shared data bus; driven only on a register read hit
//  INTin     out    1     interrupt request to CPU (registered)
//  INTnum    out    32    cause code to CPU (registered)
// BEHAVIOUR
//  Register map: hit = (Addr[31:4]==BASE_ADDR[31:4]), register = Addr[3:2].
//   +0 PEND  R / W1C  pending bits [NSRC-1:0]; upper bits read 0
//   +4 MASK  R/W      1 = source enabled
//   +8 CAUSE R        {valid, 26'b0, idx[4:0]} for the current winner
//   +C FORCE W        write-1-to-set PEND (software trigger); reads 0
//  Reset:
//   - PEND=0, MASK=0, sync/history flops=0, INTin=0, INTnum=0, BUS=z.
//   - Reset mid-request discards all pending state.
//  Synchronisation:
//   - irq_src passes two sync flops (s1,s2) plus a history flop s3.
//   - rise = s2 & ~s3 sets PEND.
//   - A source edge sampled at posedge k sets PEND at posedge k+2.
//   - Held-high levels cause no re-set after a clear.
//  Priority:
//   - act = PEND & MASK; the lowest set index wins.
//   - valid = |act.
//  Outputs, registered each cycle from act:
//   - INTin <= valid.
//   - INTnum <= valid ? CODE_BASE+idx : 0.
//   - So PEND set at k+2 gives INTin=1 after posedge k+3.
//  Read path, combinational:
//   - BUS = (Memread & hit & Memwrite==0) ? reg : 32'bz.
//   - Held stable while Memread is high so the CPU samples it a cycle later.
//  Write path: commits on the posedge where Memwrite is 1 or 3 and hit.
//   - WORD uses BUS[31:0].
//   - BYTE updates bits [7:0] only, from BUS[7:0].
//   - Memwrite==2 (DMA) is ignored.
//  Simultaneous events, applied per bit in this order:
//   - PEND_next = (PEND & ~w1c) | rise | force.
//   - A new edge in the same cycle as a W1C of that bit leaves it pending, so it is never lost.
//  MASK changes affect INTin on the next edge; PEND is unaffected by MASK.
//  INTin stays high until the handler clears PEND or MASK.
//   - The CPU has no ack line and gates on its own STATUS[0].
//   - The handler must clear before eret, otherwise the interrupt re-enters.
//  Addresses outside the 16-byte window: no BUS drive, no state change.
// TESTING
//  Reset, then MASK=0x01 and pulse irq_src[0] for 1 cycle.
//   -> PEND=0x01 after 2 edges, INTin=1 and INTnum=16 one edge later.
//  PEND=0x0C, MASK=0xFF
//   -> INTnum=18 and CAUSE=0x8000_0002.
//   -> Then W1C 0x04 -> INTnum=19 and CAUSE=0x8000_0003.
//  irq_src[1] rises in the same cycle as a W1C of bit 1
//   -> PEND[1] remains 1 and INTin stays 1.
//  MASK=0, force 0x80
//   -> PEND=0x80 and INTin=0.
//   -> Then MASK=0x80 -> INTin=1 and INTnum=23.
//  BYTE write of 0x5A to MASK while MASK=0xFFFF_FFFF (NSRC=32)
//   -> MASK=0xFFFF_FF5A.
//   -> A DMA write of the same value leaves MASK unchanged.
//  Reassert rst while INTin=1
//   -> next edge: INTin=0, INTnum=0, PEND=MASK=0, BUS=z during a Memread hit.

Source files
------------

// File: rtl/int_ctrl.sv
// Bus-mapped interrupt controller feeding the CPU's INTin/INTnum inputs.
// Request lines are synchronised, edge-detected into PEND, masked, and the
// lowest-index active source is presented to the CPU as a registered request
// plus cause code. Software accesses PEND/MASK/CAUSE/FORCE via word loads/stores.
module int_ctrl #(
    parameter int unsigned NSRC      = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned CODE_BASE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic [31:0]     Addr,
    input  logic            Memread,
    input  logic [1:0]      Memwrite,
    inout  wire  [31:0]     BUS,
    output logic            INTin,
    output logic [31:0]     INTnum
);

    typedef enum logic [1:0] {
        REG_PEND  = 2'd0,
        REG_MASK  = 2'd1,
        REG_CAUSE = 2'd2,
        REG_FORCE = 2'd3
    } reg_e;

    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] pend, mask;
    logic [NSRC-1:0] rise, w1c, frc, act;
    logic [31:0]     pend32, mask32, wval32, mask_wr32, rdata;
    logic            hit, wr_byte, wr_en, rd_en, valid;
    logic [4:0]      idx;
    reg_e            sel;
    logic            unused_bits;

    assign sel     = reg_e'(Addr[3:2]);
    assign hit     = (Addr[31:4] == BASE_ADDR[31:4]);
    assign wr_byte = (Memwrite == 2'd3);
    assign wr_en   = hit && ((Memwrite == 2'd1) || wr_byte);
    assign rd_en   = Memread && hit && (Memwrite == 2'd0) && !rst;

    assign unused_bits = ^{Addr[1:0], wval32, mask_wr32};

    // Zero-extended 32-bit register views and byte/word write data shaping.
    always_comb begin
        pend32 = '0;
        mask32 = '0;
        pend32[NSRC-1:0] = pend;
        mask32[NSRC-1:0] = mask;
        // BYTE stores touch only bits [7:0]; for W1C/FORCE the untouched
        // bits behave as if written with 0, for MASK they keep their value.
        wval32    = wr_byte ? {24'b0, BUS[7:0]} : BUS;
        mask_wr32 = wr_byte ? {mask32[31:8], BUS[7:0]} : BUS;
    end

    assign rise = s2 & ~s3;
    assign w1c  = (wr_en && sel == REG_PEND)  ? wval32[NSRC-1:0] : '0;
    assign frc  = (wr_en && sel == REG_FORCE) ? wval32[NSRC-1:0] : '0;
    assign act  = pend & mask;

    // Fixed priority: lowest set index of the active vector wins.
    always_comb begin
        valid = |act;
        idx   = '0;
        for (int unsigned i = NSRC; i > 0; i--) begin
            if (act[i-1]) idx = 5'(i - 1);
        end
    end

    // Synchroniser, history, pending/mask state and registered CPU outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            pend   <= '0;
            mask   <= '0;
            INTin  <= 1'b0;
            INTnum <= '0;
        end else begin
            s1   <= irq_src;
            s2   <= s1;
            s3   <= s2;
            // Clear is applied before set so a same-cycle edge is never lost.
            pend <= (pend & ~w1c) | rise | frc;
            if (wr_en && sel == REG_MASK) mask <= mask_wr32[NSRC-1:0];
            INTin  <= valid;
            INTnum <= valid ? (32'(CODE_BASE) + {27'b0, idx}) : '0;
        end
    end

    // Register read mux; FORCE is write-only and reads as zero.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_PEND:  rdata = pend32;
            REG_MASK:  rdata = mask32;
            REG_CAUSE: rdata = {valid, 26'b0, idx};
            REG_FORCE: rdata = '0;
            default:   rdata = '0;
        endcase
    end

    assign BUS = rd_en ? rdata : 'z;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by random
// traffic, compared against an event-level reference model of the controller.
module tb_int_ctrl;

    localparam int unsigned NSRC      = 32;
    localparam logic [31:0] BASE      = 32'hFFFF_FF00;
    localparam int unsigned CODE_BASE = 16;

    logic        clk;
    logic        rst;
    logic [31:0] irq_src;
    logic [31:0] Addr;
    logic        Memread;
    logic [1:0]  Memwrite;
    logic        INTin;
    logic [31:0] INTnum;
    logic [31:0] bus_drv;
    logic        bus_oe;
    wire  [31:0] BUS;

    assign BUS = bus_oe ? bus_drv : 'z;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pend, m_mask;
    logic [31:0] h1, h2, h3;   // irq_src samples taken 1, 2, 3 edges ago

    int_ctrl #(
        .NSRC(NSRC),
        .BASE_ADDR(BASE),
        .CODE_BASE(CODE_BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_src(irq_src),
        .Addr(Addr),
        .Memread(Memread),
        .Memwrite(Memwrite),
        .BUS(BUS),
        .INTin(INTin),
        .INTnum(INTnum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest(logic [31:0] a);
        return $clog2(a & (~a + 32'd1));
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] act;
        act = m_pend & m_mask;
        if (act == 0) return 32'h0;
        return 32'h8000_0000 | 32'(lowest(act));
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model from the inputs currently applied,
    // then compare the registered outputs just after the edge.
    task automatic step();
        logic [31:0] act, rise, wv, w1c, frc, nmask;
        logic        e_intin;
        logic [31:0] e_intnum;
        logic        hit;
        logic [1:0]  r;
        act      = m_pend & m_mask;
        e_intin  = (act != 0);
        e_intnum = (act != 0) ? 32'(CODE_BASE + lowest(act)) : 32'h0;
        hit      = ((Addr >> 4) == (BASE >> 4));
        r        = Addr[3:2];
        w1c = 0; frc = 0; nmask = m_mask;
        if (hit && bus_oe && (Memwrite == 2'd1 || Memwrite == 2'd3)) begin
            wv = (Memwrite == 2'd3) ? (bus_drv & 32'hFF) : bus_drv;
            case (r)
                2'd0: w1c = wv;
                2'd1: nmask = (Memwrite == 2'd3) ? ((m_mask & ~32'hFF) | wv) : wv;
                2'd3: frc = wv;
                default: ;
            endcase
        end
        rise = h2 & ~h3;
        if (rst) begin
            m_pend = 0; m_mask = 0; h1 = 0; h2 = 0; h3 = 0;
            e_intin = 0; e_intnum = 0;
        end else begin
            m_pend = (m_pend & ~w1c) | rise | frc;
            m_mask = nmask;
            h3 = h2; h2 = h1; h1 = irq_src;
        end
        @(posedge clk);
        #1;
        check("intin", {31'b0, INTin}, {31'b0, e_intin});
        check("intnum", INTnum, e_intnum);
    endtask

    task automatic wr(int unsigned off, logic [31:0] v, logic [1:0] mw);
        Memread  = 1'b0;
        Addr     = BASE + off;
        Memwrite = mw;
        bus_drv  = v;
        bus_oe   = 1'b1;
        step();
        Memwrite = 2'd0;
        bus_oe   = 1'b0;
        Addr     = '0;
    endtask

    task automatic rd(int unsigned off, logic [31:0] exp, string tag);
        Addr     = BASE + off;
        Memwrite = 2'd0;
        bus_oe   = 1'b0;
        Memread  = 1'b1;
        #1;
        check(tag, BUS, exp);
        Memread = 1'b0;
        Addr    = '0;
        #1;
    endtask

    task automatic rd_model(int unsigned off);
        case (off)
            0:  rd(0,  m_pend,    "rd_pend");
            4:  rd(4,  m_mask,    "rd_mask");
            8:  rd(8,  m_cause(), "rd_cause");
            default: rd(12, 32'h0, "rd_force");
        endcase
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; Addr = '0; Memread = 1'b0;
        Memwrite = 2'd0; bus_drv = '0; bus_oe = 1'b0;
        m_pend = 0; m_mask = 0; h1 = 0; h2 = 0; h3 = 0;

        // Reset state
        step(); step();
        rst = 1'b0;
        step();
        check("rst_intin", {31'b0, INTin}, 32'h0);
        check("rst_intnum", INTnum, 32'h0);
        rd(0, 32'h0, "rst_pend");
        rd(4, 32'h0, "rst_mask");

        // Single-cycle pulse on source 0 with MASK=1
        wr(4, 32'h1, 2'd1);
        irq_src = 32'h1;
        step();                        // edge k samples the pulse
        irq_src = 32'h0;
        step();                        // k+1
        rd(0, 32'h0, "pend_k1");
        step();                        // k+2
        rd(0, 32'h1, "pend_k2");
        check("intin_k2", {31'b0, INTin}, 32'h0);
        step();                        // k+3
        check("intin_k3", {31'b0, INTin}, 32'h1);
        check("intnum_16", INTnum, 32'd16);
        wr(0, 32'h1, 2'd1);

        // Priority among PEND=0x0C, then W1C of the winner
        wr(12, 32'h0C, 2'd1);
        wr(4, 32'hFF, 2'd1);
        step();
        check("intnum_18", INTnum, 32'd18);
        rd(8, 32'h8000_0002, "cause_2");
        wr(0, 32'h04, 2'd1);
        step();
        check("intnum_19", INTnum, 32'd19);
        rd(8, 32'h8000_0003, "cause_3");
        wr(0, 32'hFFFF_FFFF, 2'd1);
        step();

        // New edge coinciding with W1C of the same bit
        irq_src = 32'h2; step(); irq_src = 32'h0; step(); step(); step();
        check("intin_src1", {31'b0, INTin}, 32'h1);
        irq_src = 32'h2; step(); step();
        wr(0, 32'h2, 2'd1);             // rise of bit 1 lands on this edge
        rd(0, 32'h2, "pend_kept");
        step();
        check("intin_kept", {31'b0, INTin}, 32'h1);
        // Held-high level: clearing again does not re-set the bit
        wr(0, 32'h2, 2'd1);
        step(); step();
        rd(0, 32'h0, "held_no_reset");
        check("intin_held", {31'b0, INTin}, 32'h0);
        irq_src = 32'h0;

        // Force with MASK=0, then enable
        wr(4, 32'h0, 2'd1);
        wr(12, 32'h80, 2'd1);
        step();
        rd(0, 32'h80, "pend_forced");
        check("intin_masked", {31'b0, INTin}, 32'h0);
        wr(4, 32'h80, 2'd1);
        step();
        check("intin_unmask", {31'b0, INTin}, 32'h1);
        check("intnum_23", INTnum, 32'd23);

        // BYTE and DMA writes to MASK, plus a miss just outside the window
        wr(4, 32'hFFFF_FFFF, 2'd1);
        wr(4, 32'h0000_005A, 2'd3);
        rd(4, 32'hFFFF_FF5A, "mask_byte");
        wr(4, 32'h0000_005A, 2'd2);
        rd(4, 32'hFFFF_FF5A, "mask_dma");
        wr(16 + 4, 32'h0, 2'd1);
        rd(4, 32'hFFFF_FF5A, "mask_miss");
        wr(0, 32'hFFFF_FFFF, 2'd1);
        step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            irq_src = $urandom() & $urandom();
            op = $urandom_range(0, 9);
            case (op)
                0, 1: wr(0, $urandom(), 2'd1);
                2:    wr(4, $urandom(), 2'd1);
                3:    wr(4 * $urandom_range(0, 3), $urandom(), 2'd3);
                4:    wr(12, $urandom() & $urandom() & $urandom(), 2'd1);
                5:    wr(4 * $urandom_range(0, 3), $urandom(), 2'd2);
                6: begin
                    Memread  = 1'b0;
                    Addr     = (BASE ^ (32'h10 << $urandom_range(0, 27))) | 32'(4 * $urandom_range(0, 3));
                    Memwrite = 2'd1;
                    bus_drv  = $urandom();
                    bus_oe   = 1'b1;
                    step();
                    Memwrite = 2'd0; bus_oe = 1'b0; Addr = '0;
                end
                default: step();
            endcase
            rd_model(4 * $urandom_range(0, 3));
        end

        // Reset asserted while a request is active
        irq_src = '0;
        wr(4, 32'hFF, 2'd1);
        wr(12, 32'h01, 2'd1);
        step();
        check("pre_rst_intin", {31'b0, INTin}, 32'h1);
        rst = 1'b1;
        Addr = BASE + 4; Memread = 1'b1; #1;
        checks++;
        assert (BUS !== 32'h0000_00FF) else begin
            errors++;
            $error("FAIL bus_rst observed=%h expected=%s", BUS, "undriven");
        end
        Memread = 1'b0; Addr = '0;
        step();
        check("rst_mid_intin", {31'b0, INTin}, 32'h0);
        check("rst_mid_intnum", INTnum, 32'h0);
        rst = 1'b0;
        rd(0, 32'h0, "rst_mid_pend");
        rd(4, 32'h0, "rst_mid_mask");
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
